fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, start address loaded into pc on start.
REQ-002 SHALL have parameter END_WORD, default 8'hB0, instruction word driven on line when not running (decodes as end).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load_en  input  1  program-load write strobe into the internal 256x8 instruction memory.
REQ-006 SHALL have port load_addr  input  8  program-load write address.
REQ-007 SHALL have port load_data  input  8  program-load write data.
REQ-008 SHALL have port start  input  1  begin execution at RESET_PC.
REQ-009 SHALL have port goto  input  1  unconditional branch request (control goto bit).
REQ-010 SHALL have port jump  input  1  conditional branch request (control jump bit).
REQ-011 SHALL have port cond  input  1  ALU branch condition; qualifies jump.
REQ-012 SHALL have port halt_ctl  input  1  control halt bit; 1 = continue, 0 = end.
REQ-013 SHALL have port target  input  8  branch target address.
REQ-014 SHALL have port line  output  8  current instruction word to the control decoder.
REQ-015 SHALL have port pc  output  8  current program counter.
REQ-016 SHALL have port running  output  1  high in RUN state.
REQ-017 SHALL have port pc_overflow  output  1  sticky flag, sequential fetch past address 255.
REQ-018 SHALL have port instr_count  output  16  count of retired instructions, saturating.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, HALTED; pc, pc_overflow, instr_count registered.
REQ-020 SHALL in RUN drive line = mem[pc] combinationally (same-cycle read); in IDLE/HALTED drive line = END_WORD.
REQ-021 SHALL in IDLE/HALTED write load_data to mem[load_addr] on each cycle load_en=1; load_en ignored in RUN.
REQ-022 SHALL on start=1 in IDLE or HALTED: pc <= RESET_PC, pc_overflow <= 0, instr_count <= 0, state <= RUN; start ignored in RUN.
REQ-023 SHALL on start and load_en in the same cycle perform the write and the transition; the first fetch sees the written word.
REQ-024 SHALL in RUN, each cycle, apply in priority order: halt_ctl=0 -> HALTED, pc held; goto=1 -> pc <= target; jump=1 and cond=1 -> pc <= target; else pc <= pc+1.
REQ-025 SHALL treat jump=1 with cond=0 as sequential (pc+1).
REQ-026 SHALL on sequential advance with pc=8'hFF not wrap: pc held at 8'hFF, pc_overflow <= 1, state <= HALTED.
REQ-027 SHALL allow branch to any address including 8'hFF; only sequential increment past 255 is overflow.
REQ-028 SHALL increment instr_count by 1 in every RUN cycle with halt_ctl=1, saturating at 16'hFFFF; the end instruction is not counted.
REQ-029 SHALL hold pc, pc_overflow, instr_count stable in IDLE and HALTED except per REQ-022.
REQ-030 SHALL assert running combinationally from state (1 only in RUN).

Reset
REQ-031 SHALL on reset=1 at a clock edge set state IDLE, pc=RESET_PC, pc_overflow=0, instr_count=0, regardless of state or other inputs, including mid-RUN.
REQ-032 SHALL NOT clear instruction memory on reset; contents persist across reset.
REQ-033 SHALL give reset priority over start, load_en and all RUN transitions (no memory write in a reset cycle).

Verification
REQ-034 SHALL cover: load mem[0..2]=8'h20,8'h21,8'hB0, start, halt_ctl driven 1,1,0 -> line 8'h20,8'h21,8'hB0 on consecutive cycles, then HALTED, pc=2, instr_count=2, line=8'hB0.
REQ-035 SHALL cover: RUN at pc=5, goto=1 and jump=1, cond=0, target=8'h40 -> pc=8'h40 next cycle; repeat with goto=0, cond=0 -> pc=6.
REQ-036 SHALL cover: branch to 8'hFF, halt_ctl=1, no branch -> pc stays 8'hFF, pc_overflow=1, running=0; then start -> pc=RESET_PC, pc_overflow=0.
REQ-037 SHALL cover: reset asserted mid-RUN at pc=8'h12 -> next cycle IDLE, pc=0, instr_count=0, line=8'hB0; memory word previously loaded at 8'h00 still read after start.
REQ-038 SHALL cover: load_en=1 during RUN with load_addr=pc+1 -> memory unchanged, fetched word equals original.
REQ-039 SHALL cover: start and load_en (addr 8'h00, data 8'h35) same cycle in IDLE -> first line in RUN = 8'h35.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit and its environment: program-load port,
// control-decoder branch/halt inputs and the fetch outputs.
interface fetch_unit_if;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [7:0]  load_data;
    logic        start;
    logic        goto;
    logic        jump;
    logic        cond;
    logic        halt_ctl;
    logic [7:0]  target;
    logic [7:0]  line;
    logic [7:0]  pc;
    logic        running;
    logic        pc_overflow;
    logic [15:0] instr_count;

    modport master (
        output load_en, load_addr, load_data, start, goto, jump, cond, halt_ctl, target,
        input  line, pc, running, pc_overflow, instr_count
    );

    modport slave (
        input  load_en, load_addr, load_data, start, goto, jump, cond, halt_ctl, target,
        output line, pc, running, pc_overflow, instr_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: 256x8 program memory, IDLE/RUN/HALTED sequencer,
// branch handling, sticky sequential-overflow flag and retired-instruction counter.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] END_WORD = 8'hB0
) (
    input logic         clock,
    input logic         reset,
    fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t      state;
    logic [7:0]  mem [256];
    logic [7:0]  pc_q;
    logic        overflow_q;
    logic [15:0] count_q;

    // Memory is never cleared; writes are only accepted outside RUN and never in a reset cycle.
    always_ff @(posedge clock) begin
        if (!reset && state != RUN && bus.load_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            overflow_q <= 1'b0;
            count_q    <= 16'h0000;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (bus.start) begin
                        state      <= RUN;
                        pc_q       <= RESET_PC;
                        overflow_q <= 1'b0;
                        count_q    <= 16'h0000;
                    end
                end
                RUN: begin
                    if (!bus.halt_ctl) begin
                        state <= HALTED;
                    end else begin
                        if (count_q != 16'hFFFF) begin
                            count_q <= count_q + 16'd1;
                        end
                        // A sequential step off the top of memory halts instead of wrapping.
                        if (bus.goto || (bus.jump && bus.cond)) begin
                            pc_q <= bus.target;
                        end else if (pc_q == 8'hFF) begin
                            overflow_q <= 1'b1;
                            state      <= HALTED;
                        end else begin
                            pc_q <= pc_q + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.running     = (state == RUN);
    assign bus.line        = (state == RUN) ? mem[pc_q] : END_WORD;
    assign bus.pc          = pc_q;
    assign bus.pc_overflow = overflow_q;
    assign bus.instr_count = count_q;
endmodule
